// File: rtl/rr_distributor.sv
// rr_distributor
// ---------------
// 1-to-N round-robin distributor. It takes one valid/ready/data stream and
// steers every word to exactly one of N_DST equivalent downstream consumers.
// A single registered holding stage gives registered outputs at full
// throughput. Each new word goes to the next enabled destination after the
// previous target. A destination that is ready is preferred over one that
// is only enabled.
//
// Ports
//   i_clk     clock
//   i_rst_n   synchronous reset, active low
//   i_valid   upstream valid
//   o_ready   upstream ready; combinational from i_ready and i_dst_en only
//   i_data    upstream data word
//   o_valid   per-destination valid; one-hot or zero; registered
//   i_ready   per-destination ready
//   o_data    shared data bus to all destinations; registered
//   i_dst_en  destination enable mask; quasi-static
module rr_distributor #(
    parameter int N_DST = 8,
    parameter int DATAW = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [DATAW-1:0] i_data,
    output logic [N_DST-1:0] o_valid,
    input  logic [N_DST-1:0] i_ready,
    output logic [DATAW-1:0] o_data,
    input  logic [N_DST-1:0] i_dst_en
);

    localparam int          PW      = (N_DST > 1) ? $clog2(N_DST) : 1;
    localparam logic [PW:0] N_DST_W = (PW+1)'(N_DST);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     last_q, last_d;
    logic [N_DST-1:0]  valid_q, valid_d;
    logic [DATAW-1:0]  data_q, data_d;

    logic              done;
    logic              accept;
    logic [PW-1:0]     target;
    logic [PW-1:0]     tgt_ready, tgt_en;
    logic              found_ready, found_en;
    logic [PW:0]       sum;
    logic [PW-1:0]     idx;
    logic [N_DST-1:0]  target_onehot;

    assign done    = |(valid_q & i_ready);
    assign o_ready = (|i_dst_en) & ((state_q == EMPTY) | done);
    assign accept  = i_valid & o_ready;
    assign o_valid = valid_q;
    assign o_data  = data_q;

    // Scan from last+1 round to last itself. The wrap is a compare and
    // subtract, so a destination count that is not a power of two also
    // works. The first enabled and ready destination wins. If none is
    // ready, the first enabled destination takes the word and holds it.
    always_comb begin
        tgt_ready   = '0;
        tgt_en      = '0;
        found_ready = 1'b0;
        found_en    = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 1; k <= N_DST; k++) begin
            sum = {1'b0, last_q} + (PW+1)'(k);
            if (sum >= N_DST_W) begin
                sum = sum - N_DST_W;
            end
            idx = sum[PW-1:0];
            if (!found_ready && i_dst_en[idx] && i_ready[idx]) begin
                tgt_ready   = idx;
                found_ready = 1'b1;
            end
            if (!found_en && i_dst_en[idx]) begin
                tgt_en   = idx;
                found_en = 1'b1;
            end
        end
        target = found_ready ? tgt_ready : tgt_en;
    end

    // Decode the selected target into its one-hot valid pattern
    always_comb begin
        target_onehot = '0;
        for (int i = 0; i < N_DST; i++) begin
            target_onehot[i] = (target == PW'(i));
        end
    end

    // Holding-stage next state. An accept while FULL only happens in a
    // cycle where the held word also departs, so it covers the no-bubble
    // case. A held word that is not done keeps its target and data.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            state_d = FULL;
            last_d  = target;
            valid_d = target_onehot;
            data_d  = i_data;
        end else if (done) begin
            state_d = EMPTY;
            valid_d = '0;
        end
    end

    // The pointer resets to the highest index, so the first search starts at 0
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            last_q  <= PW'(N_DST - 1);
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_rr_distributor.sv
// tb_rr_distributor
// -----------------
// Self-checking bench for rr_distributor with N_DST=4 and DATAW=8.
// A behavioural model tracks the held word, its target and the pointer
// using plain modular arithmetic. Directed scenarios run first, followed by
// a randomized phase. Every cycle, outputs are compared against the model.
module tb_rr_distributor;

    localparam int N = 4;
    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_data;
    logic [N-1:0] o_valid;
    logic [N-1:0] i_ready;
    logic [W-1:0] o_data;
    logic [N-1:0] i_dst_en;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model state: whether a word is held, its target (= last pointer), its data
    bit           mFull;
    int           mLast;
    logic [W-1:0] mData;

    rr_distributor #(.N_DST(N), .DATAW(W)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .i_dst_en (i_dst_en)
    );

    // Free-running clock
    always #5 i_clk = ~i_clk;

    // Single comparison point: count, assert, report
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs against the model under the current inputs
    task automatic checkOutput();
        logic [N-1:0] expValid;
        logic         expReady;
        expValid = mFull ? N'(1 << mLast) : '0;
        expReady = (i_dst_en != '0) && (!mFull || i_ready[mLast]);
        checkVal("o_valid", 32'(o_valid), 32'(expValid));
        checkVal("o_data", 32'(o_data), 32'(mData));
        checkVal("o_ready", 32'(o_ready), 32'(expReady));
        checkVal("onehot0", 32'($onehot0(o_valid)), 32'd1);
        if (i_dst_en == '0) begin
            checkVal("no_accept_disabled", 32'(o_ready & i_valid), 32'd0);
        end
    endtask

    // Advance the model by one clock edge using the rules of the distributor
    task automatic modelStep();
        bit doneM, readyM;
        int t;
        if (!i_rst_n) begin
            mFull = 1'b0;
            mLast = N - 1;
            mData = '0;
        end else begin
            doneM  = mFull && i_ready[mLast];
            readyM = (i_dst_en != '0) && (!mFull || doneM);
            if (i_valid && readyM) begin
                t = -1;
                for (int k = 1; k <= N; k++) begin
                    if (t < 0 && i_dst_en[(mLast + k) % N] && i_ready[(mLast + k) % N])
                        t = (mLast + k) % N;
                end
                for (int k = 1; k <= N; k++) begin
                    if (t < 0 && i_dst_en[(mLast + k) % N])
                        t = (mLast + k) % N;
                end
                mLast = t;
                mData = i_data;
                mFull = 1'b1;
            end else if (doneM) begin
                mFull = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, check pre-edge outputs, then clock it in
    task automatic applyStimulus(input bit rstN, input bit v, input logic [W-1:0] d,
                                 input logic [N-1:0] r, input logic [N-1:0] en);
        i_rst_n  = rstN;
        i_valid  = v;
        i_data   = d;
        i_ready  = r;
        i_dst_en = en;
        #1;
        checkOutput();
        modelStep();
        @(posedge i_clk);
        #1;
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        i_ready  = '1;
        i_dst_en = '1;
        repeat (2) @(posedge i_clk);
        #1;
        mFull = 1'b0;
        mLast = N - 1;
        mData = '0;
        i_rst_n = 1'b1;
        #1;

        // Reset state and the first word
        checkVal("rst_o_valid", 32'(o_valid), 32'd0);
        checkVal("rst_o_data", 32'(o_data), 32'd0);
        checkVal("rst_o_ready", 32'(o_ready), 32'd1);
        applyStimulus(1, 1, 8'h10, 4'b0000, 4'b1111);
        checkVal("first_dest0", 32'(o_valid), 32'h1);
        checkVal("first_data", 32'(o_data), 32'h10);

        // Back-to-back words with every destination ready
        applyStimulus(0, 0, 8'h00, 4'b1111, 4'b1111);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 1, 8'(k), 4'b1111, 4'b1111);
            checkVal("b2b_dest", 32'(o_valid), 32'(1 << (k % 4)));
            checkVal("b2b_data", 32'(o_data), 32'(k));
        end
        applyStimulus(1, 0, 8'h00, 4'b1111, 4'b1111);

        // Only destination 2 ready
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 8'(8'hA0 + k), 4'b0100, 4'b1111);
            checkVal("only2_dest", 32'(o_valid), 32'h4);
            checkVal("only2_data", 32'(o_data), 32'(8'hA0 + k));
        end
        applyStimulus(1, 0, 8'h00, 4'b0100, 4'b1111);

        // Nobody ready with last=1: hold at dest 2 until it becomes ready
        applyStimulus(0, 0, 8'h00, 4'b1111, 4'b1111);
        applyStimulus(1, 1, 8'h01, 4'b1111, 4'b1111);
        applyStimulus(1, 1, 8'h02, 4'b1111, 4'b1111);
        applyStimulus(1, 0, 8'h00, 4'b1111, 4'b1111);
        applyStimulus(1, 1, 8'h55, 4'b0000, 4'b1111);
        checkVal("stall_dest2", 32'(o_valid), 32'h4);
        checkVal("stall_ready0", 32'(o_ready), 32'd0);
        applyStimulus(1, 1, 8'h66, 4'b0001, 4'b1111);
        checkVal("stall_hold_valid", 32'(o_valid), 32'h4);
        checkVal("stall_hold_data", 32'(o_data), 32'h55);
        checkVal("stall_hold_ready", 32'(o_ready), 32'd0);
        applyStimulus(1, 0, 8'h00, 4'b0100, 4'b1111);
        checkVal("stall_release", 32'(o_valid), 32'h0);

        // Sparse enable mask, then disable everything while a word is held
        applyStimulus(0, 0, 8'h00, 4'b1111, 4'b1010);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 8'(8'hB0 + k), 4'b1111, 4'b1010);
            checkVal("mask_dest", 32'(o_valid), (k % 2 == 0) ? 32'h2 : 32'h8);
        end
        applyStimulus(1, 0, 8'h00, 4'b0000, 4'b1010);
        checkVal("mask_held", 32'(o_valid), 32'h8);
        applyStimulus(1, 1, 8'hCC, 4'b1111, 4'b0000);
        checkVal("dis_delivered", 32'(o_valid), 32'h0);
        checkVal("dis_data_kept", 32'(o_data), 32'hB3);
        checkVal("dis_ready", 32'(o_ready), 32'd0);

        // Reset while a word is held at dest 1
        applyStimulus(0, 0, 8'h00, 4'b1111, 4'b1111);
        applyStimulus(1, 1, 8'hD0, 4'b0010, 4'b1111);
        checkVal("prerst_dest1", 32'(o_valid), 32'h2);
        applyStimulus(0, 1, 8'hD1, 4'b0000, 4'b1111);
        checkVal("midrst_valid", 32'(o_valid), 32'h0);
        checkVal("midrst_data", 32'(o_data), 32'h0);
        applyStimulus(1, 1, 8'hD2, 4'b0000, 4'b1111);
        checkVal("postrst_dest0", 32'(o_valid), 32'h1);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 49) != 0),
                          ($urandom_range(0, 3) != 0),
                          8'($urandom),
                          4'($urandom),
                          ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b1111);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/rr_distributor.md
Name: rr_distributor

Overview:
- 1-to-N round-robin distributor; mirror of the N-to-1 round-robin arbiter.
- Accepts one valid/ready/data stream and steers each word to exactly one of N_DST downstream consumers. Selection is round-robin among enabled consumers, with preference for consumers that are ready.
- Sits between a single producer and a pool of equivalent workers (load balancing).
- Single-entry registered holding stage: registered outputs, full throughput.

Parameters:
N_DST, 8, number of downstream destinations (>=2)
DATAW, 64, data bus width

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous reset, active low
i_valid  input  1  upstream valid
o_ready  output  1  upstream ready (combinational, see Behaviour)
i_data  input  DATAW  upstream data
o_valid  output  N_DST  per-destination valid, one-hot or zero, registered
i_ready  input  N_DST  per-destination ready
o_data  output  DATAW  shared data bus to all destinations, registered
i_dst_en  input  N_DST  destination enable mask, quasi-static

Behaviour:
- Interface: reset i_rst_n, synchronous, active-low; clock i_clk.
- Reset values:
  - full=0, o_valid=0, o_data=0.
  - Last-target pointer last = N_DST-1, so the first search starts at destination 0.
- State: single holding register with states EMPTY (full=0) and FULL (full=1). o_valid is nonzero iff FULL.
- Handshake signals:
  - done = |(o_valid & i_ready).
  - accept = i_valid & o_ready.
  - o_ready = (|i_dst_en) & (~full | done). Combinational from i_ready and i_dst_en only; no path from i_valid.
- Target selection (evaluated in the accept cycle):
  - Search order: (last+1) mod N_DST, (last+2) mod N_DST, ..., last.
  - target = first index in that order with i_dst_en & i_ready set.
  - If none, target = first index with i_dst_en set.
  - On accept: last <= target, o_data <= i_data, o_valid <= onehot(target), full <= 1.
- Latency: the word appears on o_data/o_valid the cycle after accept.
- Hold rule:
  - While FULL and not done, o_valid and o_data are held unchanged.
  - The target never changes or retracts, even if i_dst_en or i_ready of other destinations change.
- Transfer: done clears the word.
  - done & ~accept: full <= 0, o_valid <= 0. o_data keeps its last value.
  - done & accept in the same cycle: the new word loads with no bubble (1 word/cycle sustained). The search uses the current last, which equals the departing target.
- EMPTY & ~i_valid: no change.
- i_dst_en == 0: o_ready=0, so no new accepts. A word already held is still delivered to its target.
- Only o_valid[target] is ever set. Destinations must ignore o_data when their o_valid bit is low.
- Reset mid-operation: the held word is discarded; all state returns to reset values the next cycle.
- Pointer arithmetic: $clog2(N_DST) bits, mod N_DST wrap, correct for non-power-of-2 N_DST.
- Assertions (bench):
  - $onehot0(o_valid).
  - o_valid/o_data stable while FULL & ~done.
  - No accept when i_dst_en==0.

Test Plan (N_DST=4, DATAW=8, i_dst_en=4'b1111 unless stated):
1. Hold i_rst_n=0 for 2 cycles, then release -> o_valid=0, o_data=0, o_ready=1; first word 0x10 goes to dest 0.
2. All i_ready=1, back-to-back words 0x00..0x07 -> delivered in order to dests 0,1,2,3,0,1,2,3, one per cycle, o_ready constantly 1.
3. Only i_ready[2]=1, words 0xA0..0xA3 -> all go to dest 2 (o_valid=4'b0100), full throughput.
4. All i_ready=0, word 0x55 with last=1 -> o_valid=4'b0100 held and o_ready=0. Then raise i_ready[0] only -> no transfer. Then raise i_ready[2] -> transfer, o_valid=0 next cycle.
5. i_dst_en=4'b1010, all ready, 4 words -> dests 1,3,1,3. Set i_dst_en=0 while a word is held -> the word is still delivered and o_ready stays 0.
6. Assert i_rst_n=0 while FULL with o_valid=4'b0010 -> next cycle o_valid=0, and the next word goes to dest 0.
